// File: rtl/sdram_refresh_ctrl.sv
// sdram_refresh_ctrl
//   Periodic AUTO REFRESH engine that follows sdram_initialize. After ofin from
//   that block has been seen, the controller owes one refresh every REF_INTERVAL
//   clocks. For each refresh it requests the command bus, issues PRECHARGE ALL,
//   waits TRP, issues AUTO REFRESH, waits TRC, and then releases the bus with a
//   one-cycle ack.
//
//   Optional feature macro: SDRAM_REF_DEBT_EN
//     defined   : multi-refresh debt counter saturating at MAX_DEBT. One grant
//                 drains all owed refreshes back-to-back after a single PRECHARGE.
//     undefined : 1-bit debt. Exactly one AUTO REFRESH per grant. Ticks that
//                 arrive while a refresh is already owed are dropped.
//
//   Ports
//     iclk        system clock, rising edge
//     ireset_n    asynchronous active-low reset
//     iinit_fin   initialisation done, sticky-latched
//     iref_gnt    command bus grant, sampled only while requesting
//     oref_req    bus request, held until oref_ack
//     oref_ack    one-cycle pulse: sequence complete, bus released
//     obusy       high from the PRECHARGE cycle through the ack cycle
//     odebt       number of refreshes currently owed
//     DRAM_*      registered SDRAM command strobes, address and bank
//
//   state  | meaning
//   S_OFF  | waiting for init latch, bus deselected
//   S_IDLE | armed, no refresh owed
//   S_REQ  | oref_req high, waiting for grant
//   S_PRE  | PRECHARGE ALL on the bus
//   S_TRP  | NOPs until tRP has elapsed
//   S_REF  | AUTO REFRESH on the bus
//   S_TRC  | NOPs until tRC has elapsed
//   S_DONE | ack pulse, bus released
module sdram_refresh_ctrl #(
    parameter int REF_INTERVAL = 780,
    parameter int TRP          = 2,
    parameter int TRC          = 7,
    parameter int MAX_DEBT     = 8
) (
    input  logic        iclk,
    input  logic        ireset_n,
    input  logic        iinit_fin,
    input  logic        iref_gnt,
    output logic        oref_req,
    output logic        oref_ack,
    output logic        obusy,
    output logic [3:0]  odebt,
    output logic        DRAM_CS_N,
    output logic        DRAM_RAS_N,
    output logic        DRAM_CAS_N,
    output logic        DRAM_WE_N,
    output logic [12:0] DRAM_ADDR,
    output logic [1:0]  DRAM_BA
);

    localparam int CW   = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int TMAX = (TRP > TRC) ? TRP : TRC;
    localparam int TW   = $clog2(TMAX + 1);

`ifdef SDRAM_REF_DEBT_EN
    localparam int DW    = 4;
    localparam logic BURST = 1'b1;
    localparam logic [DW-1:0] DEBT_CAP = DW'(MAX_DEBT);
`else
    localparam int DW    = 1;
    localparam logic BURST = 1'b0;
    // MAX_DEBT is 1..15, so a 1-bit debt always caps at 1.
    localparam logic [DW-1:0] DEBT_CAP = DW'(MAX_DEBT >= 1);
`endif

    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;

    // Wait states are entered one cycle after the command, so they hold N-2.
    localparam logic [TW-1:0] TRP_LOAD = TW'((TRP > 1) ? TRP - 2 : 0);
    localparam logic [TW-1:0] TRC_LOAD = TW'((TRC > 1) ? TRC - 2 : 0);

    typedef enum logic [2:0] {
        S_OFF, S_IDLE, S_REQ, S_PRE, S_TRP, S_REF, S_TRC, S_DONE
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   tmr_q;
    logic            init_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   debt_q, debt_d;
    logic            tick;
    logic            ar_fire;
    logic            more_ref;
    logic [3:0]      cmd_q;
    logic            a10_q;
    logic            req_q, ack_q, busy_q;

    assign tick     = init_q && (cnt_q == CW'(REF_INTERVAL - 1));
    assign more_ref = BURST && (debt_q != '0);

    // High on the edge that puts AUTO REFRESH on the bus; debt decrements here.
    always_comb begin
        ar_fire = 1'b0;
        case (state_q)
            S_PRE:   ar_fire = (TRP == 1);
            S_TRP:   ar_fire = (tmr_q == '0);
            S_REF:   ar_fire = (TRC == 1) && more_ref;
            S_TRC:   ar_fire = (tmr_q == '0) && more_ref;
            default: ar_fire = 1'b0;
        endcase
    end

    always_comb begin
        debt_d = debt_q;
        if (tick && !ar_fire) begin
            if (debt_q != DEBT_CAP) debt_d = debt_q + 1'b1;
        end else if (ar_fire && !tick) begin
            if (debt_q != '0) debt_d = debt_q - 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            init_q <= 1'b0;
            cnt_q  <= '0;
            debt_q <= '0;
        end else begin
            init_q <= init_q | iinit_fin;
            if (init_q) cnt_q <= tick ? '0 : cnt_q + 1'b1;
            debt_q <= debt_d;
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q <= S_OFF;
            tmr_q   <= '0;
            cmd_q   <= CMD_DESEL;
            a10_q   <= 1'b0;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_OFF: begin
                    if (init_q) state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (debt_q != '0) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (iref_gnt) begin
                        state_q <= S_PRE;
                        cmd_q   <= CMD_PRE;
                        a10_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_PRE: begin
                    a10_q <= 1'b0;
                    if (ar_fire) begin
                        state_q <= S_REF;
                        cmd_q   <= CMD_AREF;
                    end else begin
                        state_q <= S_TRP;
                        cmd_q   <= CMD_NOP;
                        tmr_q   <= TRP_LOAD;
                    end
                end
                S_TRP: begin
                    if (ar_fire) begin
                        state_q <= S_REF;
                        cmd_q   <= CMD_AREF;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_REF: begin
                    if (ar_fire) begin
                        cmd_q <= CMD_AREF;
                    end else if (TRC == 1) begin
                        state_q <= S_DONE;
                        cmd_q   <= CMD_DESEL;
                        req_q   <= 1'b0;
                        ack_q   <= 1'b1;
                    end else begin
                        state_q <= S_TRC;
                        cmd_q   <= CMD_NOP;
                        tmr_q   <= TRC_LOAD;
                    end
                end
                S_TRC: begin
                    if (ar_fire) begin
                        state_q <= S_REF;
                        cmd_q   <= CMD_AREF;
                    end else if (tmr_q == '0) begin
                        state_q <= S_DONE;
                        cmd_q   <= CMD_DESEL;
                        req_q   <= 1'b0;
                        ack_q   <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_OFF;
                    cmd_q   <= CMD_DESEL;
                end
            endcase
        end
    end

    assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = cmd_q;
    assign DRAM_ADDR = {2'b00, a10_q, 10'b0};
    assign DRAM_BA   = 2'b00;
    assign odebt     = 4'(debt_q);
    assign oref_req  = req_q;
    assign oref_ack  = ack_q;
    assign obusy     = busy_q;

endmodule

// File: tb/tb_sdram_refresh_ctrl.sv
module tb_sdram_refresh_ctrl;

    localparam int REF = 780;
    localparam int TRP = 2;
    localparam int TRC = 7;
`ifdef SDRAM_REF_DEBT_EN
    localparam int CAP   = 8;
    localparam bit BURST = 1'b1;
`else
    localparam int CAP   = 1;
    localparam bit BURST = 1'b0;
`endif
    localparam logic [3:0] C_DES = 4'b1111;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;

    logic        iclk = 1'b0;
    logic        ireset_n = 1'b1;
    logic        iinit_fin = 1'b0;
    logic        iref_gnt = 1'b0;
    logic        oref_req, oref_ack, obusy;
    logic [3:0]  odebt;
    logic        DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N;
    logic [12:0] DRAM_ADDR;
    logic [1:0]  DRAM_BA;
    logic [3:0]  cmd;

    int checks = 0;
    int errors = 0;
    int cyc;

    sdram_refresh_ctrl dut (
        .iclk(iclk), .ireset_n(ireset_n), .iinit_fin(iinit_fin), .iref_gnt(iref_gnt),
        .oref_req(oref_req), .oref_ack(oref_ack), .obusy(obusy), .odebt(odebt),
        .DRAM_CS_N(DRAM_CS_N), .DRAM_RAS_N(DRAM_RAS_N), .DRAM_CAS_N(DRAM_CAS_N),
        .DRAM_WE_N(DRAM_WE_N), .DRAM_ADDR(DRAM_ADDR), .DRAM_BA(DRAM_BA)
    );

    always #5 iclk = ~iclk;

    assign cmd = {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};

    // Edge index since reset release: the first rising edge after release is edge 0.
    always @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) cyc <= -1;
        else           cyc <= cyc + 1;
    end

    task automatic do_reset(input bit init);
        @(negedge iclk);
        ireset_n  = 1'b0;
        iref_gnt  = 1'b0;
        iinit_fin = init;
        repeat (2) @(negedge iclk);
        ireset_n = 1'b1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) @(negedge iclk);
    endtask

    task automatic test_reset();
        #2 ireset_n = 1'b0;
        @(negedge iclk);
        checks++;
        if ({oref_req, oref_ack, obusy, odebt} !== 7'b0) begin
            errors++;
            $display("FAIL reset_status: got %b expected 0000000", {oref_req, oref_ack, obusy, odebt});
        end
        checks++;
        if ({cmd, DRAM_ADDR, DRAM_BA} !== {C_DES, 13'h0, 2'b00}) begin
            errors++;
            $display("FAIL reset_bus: got %h expected %h", {cmd, DRAM_ADDR, DRAM_BA}, {C_DES, 13'h0, 2'b00});
        end
        do_reset(1'b0);
        iref_gnt = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge iclk);
            checks++;
            if ({oref_req, DRAM_CS_N, odebt} !== 6'b010000) begin
                errors++;
                $display("FAIL no_init cyc=%0d: req/cs_n/debt got %b expected 010000", cyc, {oref_req, DRAM_CS_N, odebt});
            end
        end
    endtask

    task automatic test_first_refresh();
        int acks = 0;
        do_reset(1'b1);
        iref_gnt = 1'b1;
        while (cyc < 800) begin
            @(negedge iclk);
            if (oref_ack) acks++;
            case (cyc)
                779, 780: begin
                    checks++;
                    if ({odebt, oref_req} !== {(cyc == 780) ? 4'd1 : 4'd0, 1'b0}) begin
                        errors++;
                        $display("FAIL first_debt cyc=%0d: debt/req got %b", cyc, {odebt, oref_req});
                    end
                end
                781: begin
                    checks++;
                    if ({oref_req, cmd} !== {1'b1, C_DES}) begin
                        errors++;
                        $display("FAIL first_req: got %b expected %b", {oref_req, cmd}, {1'b1, C_DES});
                    end
                end
                782: begin
                    checks++;
                    if ({cmd, DRAM_ADDR, obusy} !== {C_PRE, 13'h0400, 1'b1}) begin
                        errors++;
                        $display("FAIL first_pre: cmd %b addr %h busy %b expected 0010 0400 1", cmd, DRAM_ADDR, obusy);
                    end
                end
                783, 790: begin
                    checks++;
                    if ({cmd, oref_ack} !== {C_NOP, 1'b0}) begin
                        errors++;
                        $display("FAIL first_nop cyc=%0d: got %b expected 01110", cyc, {cmd, oref_ack});
                    end
                end
                784: begin
                    checks++;
                    if ({cmd, DRAM_ADDR, odebt} !== {C_REF, 13'h0, 4'd0}) begin
                        errors++;
                        $display("FAIL first_aref: cmd %b addr %h debt %0d expected 0001 0000 0", cmd, DRAM_ADDR, odebt);
                    end
                end
                791: begin
                    checks++;
                    if ({oref_ack, oref_req, obusy, cmd} !== {3'b101, C_DES}) begin
                        errors++;
                        $display("FAIL first_ack: got %b expected 1011111", {oref_ack, oref_req, obusy, cmd});
                    end
                end
                792: begin
                    checks++;
                    if ({oref_ack, obusy, odebt} !== 6'b0) begin
                        errors++;
                        $display("FAIL first_release: got %b expected 000000", {oref_ack, obusy, odebt});
                    end
                end
                default: ;
            endcase
        end
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL first_ack_count: got %0d expected 1", acks);
        end
    endtask

    task automatic test_debt_accrue();
        int exp_n = BURST ? 3 : 1;
        int pre_n = 0, ar_n = 0, bad_gap = 0, first_ar = -1, last_ar = -1, ack_e = -1;
        do_reset(1'b1);
        run_to(3 * REF);
        checks++;
        if (odebt !== 4'(exp_n)) begin
            errors++;
            $display("FAIL accrue_debt: got %0d expected %0d", odebt, exp_n);
        end
        iref_gnt = 1'b1;
        for (int i = 0; i < 80 && ack_e < 0; i++) begin
            @(negedge iclk);
            if (cmd == C_PRE) pre_n++;
            if (cmd == C_REF) begin
                if (first_ar < 0) first_ar = cyc;
                if (last_ar >= 0 && cyc - last_ar != TRC) bad_gap++;
                last_ar = cyc;
                ar_n++;
            end
            if (oref_ack) ack_e = cyc;
        end
        checks++;
        if ({pre_n, ar_n, bad_gap} !== {32'd1, 32'(exp_n), 32'd0}) begin
            errors++;
            $display("FAIL accrue_seq: pre %0d aref %0d badgap %0d expected 1 %0d 0", pre_n, ar_n, bad_gap, exp_n);
        end
        checks++;
        if (first_ar !== 3 * REF + 1 + TRP) begin
            errors++;
            $display("FAIL accrue_first_aref: got %0d expected %0d", first_ar, 3 * REF + 1 + TRP);
        end
        checks++;
        if (ack_e < 0 || ack_e !== last_ar + TRC || odebt !== 4'd0) begin
            errors++;
            $display("FAIL accrue_ack: ack at %0d debt %0d expected ack at %0d debt 0", ack_e, odebt, last_ar + TRC);
        end
    endtask

    task automatic test_saturate();
        do_reset(1'b1);
        for (int k = 1; k <= 20; k++) begin
            run_to(k * REF);
            checks++;
            if (odebt !== 4'((k < CAP) ? k : CAP)) begin
                errors++;
                $display("FAIL saturate k=%0d: got %0d expected %0d", k, odebt, (k < CAP) ? k : CAP);
            end
        end
    endtask

    task automatic test_coincident();
        do_reset(1'b1);
        run_to(2 * REF - TRP - 1);
        iref_gnt = 1'b1;
        run_to(2 * REF - 1);
        checks++;
        if (odebt !== 4'd1) begin
            errors++;
            $display("FAIL coinc_before: got %0d expected 1", odebt);
        end
        run_to(2 * REF);
        checks++;
        if ({cmd, odebt} !== {C_REF, 4'd1}) begin
            errors++;
            $display("FAIL coinc_edge: cmd %b debt %0d expected 0001 1", cmd, odebt);
        end
        run_to(2 * REF + TRC);
        checks++;
        if (BURST ? ({cmd, oref_ack, odebt} !== {C_REF, 1'b0, 4'd0})
                  : ({cmd, oref_ack, odebt} !== {C_DES, 1'b1, 4'd1})) begin
            errors++;
            $display("FAIL coinc_after: cmd %b ack %b debt %0d", cmd, oref_ack, odebt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1);
        iref_gnt = 1'b1;
        run_to(REF + 6);
        checks++;
        if ({cmd, oref_req, obusy} !== {C_NOP, 2'b11}) begin
            errors++;
            $display("FAIL mid_pre_state: got %b expected 011111", {cmd, oref_req, obusy});
        end
        ireset_n = 1'b0;
        #1;
        checks++;
        if ({cmd, DRAM_ADDR, oref_req, oref_ack, obusy, odebt} !== {C_DES, 13'h0, 7'b0}) begin
            errors++;
            $display("FAIL mid_reset: cmd %b addr %h req %b ack %b busy %b debt %0d", cmd, DRAM_ADDR, oref_req, oref_ack, obusy, odebt);
        end
        repeat (2) @(negedge iclk);
        ireset_n = 1'b1;
        run_to(REF);
        checks++;
        if (oref_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_rearm_early: req got %b expected 0", oref_req);
        end
        run_to(REF + 1);
        checks++;
        if (oref_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_rearm: req got %b expected 1", oref_req);
        end
    endtask

    // Reference model keyed on edge timestamps: ticks fall on multiples of REF,
    // the first refresh follows PRECHARGE by TRP, later refreshes or the ack
    // follow the previous refresh by TRC.
    task automatic test_random();
        int seg_left = 0, p = 0, n;
        int m_debt = 0, m_pre = 0, m_last_ar = 0, m_n_ar = 0, m_idle_from = 2;
        bit m_req = 0, m_seq = 0, g, tick, ar, ack, pre, req_pre;
        int debt_pre;
        logic [3:0] e_cmd;
        do_reset(1'b1);
        for (int i = 0; i < 12000; i++) begin
            if (seg_left == 0) begin
                seg_left = $urandom_range(100, 2500);
                case ($urandom_range(0, 3))
                    0: p = 0;
                    1: p = 3;
                    2: p = 40;
                    default: p = 100;
                endcase
            end
            seg_left--;
            g = ($urandom_range(0, 99) < p);
            iref_gnt = g;
            @(negedge iclk);
            n = cyc;
            debt_pre = m_debt;
            req_pre = m_req;
            tick = (n > 0) && (n % REF == 0);
            ar = 0; ack = 0; pre = 0;
            if (m_seq) begin
                if (m_n_ar == 0) ar = (n == m_pre + TRP);
                else if (n == m_last_ar + TRC) begin
                    if (BURST && debt_pre != 0) ar = 1;
                    else ack = 1;
                end
            end else if (req_pre && g) begin
                pre = 1;
            end else if (!req_pre && n >= m_idle_from && debt_pre != 0) begin
                m_req = 1;
            end
            if (pre) begin m_seq = 1; m_pre = n; m_n_ar = 0; end
            if (ar) begin m_last_ar = n; m_n_ar++; end
            if (ack) begin m_seq = 0; m_req = 0; m_idle_from = n + 2; end
            if (tick && !ar) m_debt = (m_debt < CAP) ? m_debt + 1 : CAP;
            else if (ar && !tick) m_debt = m_debt - 1;
            e_cmd = pre ? C_PRE : ar ? C_REF : m_seq ? C_NOP : C_DES;
            checks++;
            if ({cmd, DRAM_ADDR, DRAM_BA} !== {e_cmd, pre ? 13'h0400 : 13'h0, 2'b00}) begin
                errors++;
                $display("FAIL rand_bus cyc=%0d: cmd %b addr %h expected cmd %b pre %b", n, cmd, DRAM_ADDR, e_cmd, pre);
            end
            checks++;
            if ({oref_req, oref_ack, obusy, odebt} !== {m_req, ack, m_seq | ack, 4'(m_debt)}) begin
                errors++;
                $display("FAIL rand_status cyc=%0d: req/ack/busy/debt got %b expected %b", n,
                         {oref_req, oref_ack, obusy, odebt}, {m_req, ack, m_seq | ack, 4'(m_debt)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_refresh();
        test_debt_accrue();
        test_saturate();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
